// File: rtl/coin_acceptor.sv
// Coin acceptor: collects circle/triangle/pentagon coins up to a 4-bit total,
// compares the total against a purchase cost and tracks a 0..3 coin inventory per type.
module coin_acceptor (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       coin_valid,
  input  logic [2:0] coin_in,
  input  logic       go,
  input  logic [3:0] cost,
  input  logic       result_ack,
  input  logic       dispense_valid,
  input  logic [2:0] dispense_coin,
  output logic       coin_accept,
  output logic       coin_reject,
  output logic [3:0] Paid,
  output logic       result_valid,
  output logic       less,
  output logic       exact,
  output logic       more,
  output logic [3:0] change,
  output logic [1:0] Pentagons,
  output logic [1:0] Triangles,
  output logic [1:0] Circles
);

  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, EVAL = 2'd2} state_t;

  localparam logic [2:0] CODE_CIRCLE   = 3'b001;
  localparam logic [2:0] CODE_TRIANGLE = 3'b011;
  localparam logic [2:0] CODE_PENTAGON = 3'b101;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_paid, w_paid_nxt;
  logic       r_accept, r_reject;
  logic       r_rv, r_less, r_exact, r_more;
  logic [3:0] r_change;
  logic       w_rv_nxt, w_less_nxt, w_exact_nxt, w_more_nxt;
  logic [3:0] w_change_nxt;
  logic [1:0] r_cnt_p, r_cnt_t, r_cnt_c;

  logic       w_ins_p, w_ins_t, w_ins_c;
  logic       w_dsp_p, w_dsp_t, w_dsp_c;
  logic [2:0] w_coin_val;
  logic [1:0] w_cnt_sel;
  logic [4:0] w_sum5;
  logic       w_accept, w_reject;
  logic [3:0] w_paid_cand;

  function automatic logic [1:0] inv_next(input logic [1:0] cnt, input logic inc,
                                          input logic dec);
    // Simultaneous insert and dispense of one type cancel out
    if (inc && !dec)                   return cnt + 2'd1;
    else if (dec && !inc && cnt != 0) return cnt - 2'd1;
    else                               return cnt;
  endfunction

  assign w_ins_c = (coin_in == CODE_CIRCLE);
  assign w_ins_t = (coin_in == CODE_TRIANGLE);
  assign w_ins_p = (coin_in == CODE_PENTAGON);
  assign w_dsp_c = dispense_valid && (dispense_coin == CODE_CIRCLE);
  assign w_dsp_t = dispense_valid && (dispense_coin == CODE_TRIANGLE);
  assign w_dsp_p = dispense_valid && (dispense_coin == CODE_PENTAGON);

  always_comb begin
    w_coin_val = 3'd0;
    w_cnt_sel  = 2'd3;
    if (w_ins_c) begin w_coin_val = 3'd1; w_cnt_sel = r_cnt_c; end
    if (w_ins_t) begin w_coin_val = 3'd3; w_cnt_sel = r_cnt_t; end
    if (w_ins_p) begin w_coin_val = 3'd5; w_cnt_sel = r_cnt_p; end
  end

  // Overflow guard at 5 bits so a wrapping 4-bit sum cannot sneak through
  assign w_sum5      = {1'b0, r_paid} + {2'b00, w_coin_val};
  assign w_accept    = coin_valid && (r_state != EVAL) && (w_coin_val != 3'd0) &&
                       (w_cnt_sel != 2'd3) && (w_sum5 <= 5'd15);
  assign w_reject    = coin_valid && !w_accept;
  assign w_paid_cand = w_accept ? w_sum5[3:0] : r_paid;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, COLLECT: begin
        if (go)            w_state_nxt = EVAL;
        else if (w_accept) w_state_nxt = COLLECT;
      end
      EVAL:    if (result_ack) w_state_nxt = r_less ? COLLECT : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Results are computed at the go edge from the post-coin total, then held until ack
  always_comb begin
    w_paid_nxt   = r_paid;
    w_rv_nxt     = r_rv;
    w_less_nxt   = r_less;
    w_exact_nxt  = r_exact;
    w_more_nxt   = r_more;
    w_change_nxt = r_change;
    unique case (r_state)
      IDLE, COLLECT: begin
        w_paid_nxt = w_paid_cand;
        if (go) begin
          w_rv_nxt     = 1'b1;
          w_less_nxt   = (w_paid_cand <  cost);
          w_exact_nxt  = (w_paid_cand == cost);
          w_more_nxt   = (w_paid_cand >  cost);
          w_change_nxt = (w_paid_cand > cost) ? (w_paid_cand - cost) : 4'd0;
        end
      end
      EVAL: begin
        if (result_ack) begin
          w_paid_nxt   = r_less ? r_paid : 4'd0;
          w_rv_nxt     = 1'b0;
          w_less_nxt   = 1'b0;
          w_exact_nxt  = 1'b0;
          w_more_nxt   = 1'b0;
          w_change_nxt = 4'd0;
        end
      end
      default: w_paid_nxt = 4'd0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_paid   <= 4'd0;
      r_accept <= 1'b0;
      r_reject <= 1'b0;
      r_rv     <= 1'b0;
      r_less   <= 1'b0;
      r_exact  <= 1'b0;
      r_more   <= 1'b0;
      r_change <= 4'd0;
      r_cnt_p  <= 2'd0;
      r_cnt_t  <= 2'd0;
      r_cnt_c  <= 2'd0;
    end else begin
      r_paid   <= w_paid_nxt;
      r_accept <= w_accept;
      r_reject <= w_reject;
      r_rv     <= w_rv_nxt;
      r_less   <= w_less_nxt;
      r_exact  <= w_exact_nxt;
      r_more   <= w_more_nxt;
      r_change <= w_change_nxt;
      r_cnt_p  <= inv_next(r_cnt_p, w_accept && w_ins_p, w_dsp_p);
      r_cnt_t  <= inv_next(r_cnt_t, w_accept && w_ins_t, w_dsp_t);
      r_cnt_c  <= inv_next(r_cnt_c, w_accept && w_ins_c, w_dsp_c);
    end
  end

  assign coin_accept  = r_accept;
  assign coin_reject  = r_reject;
  assign Paid         = r_paid;
  assign result_valid = r_rv;
  assign less         = r_less;
  assign exact        = r_exact;
  assign more         = r_more;
  assign change       = r_change;
  assign Pentagons    = r_cnt_p;
  assign Triangles    = r_cnt_t;
  assign Circles      = r_cnt_c;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed scenarios plus random traffic, all checked
// cycle by cycle against a transaction-level reference model.
module tb_coin_acceptor;

  logic       clock = 1'b0;
  logic       reset_L;
  logic       coin_valid, go, result_ack, dispense_valid;
  logic [2:0] coin_in, dispense_coin;
  logic [3:0] cost;
  logic       coin_accept, coin_reject, result_valid, less, exact, more;
  logic [3:0] Paid, change;
  logic [1:0] Pentagons, Triangles, Circles;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: total, per-type coin counts, whether a result is pending
  int m_paid;
  int m_cnt[3];
  bit m_eval, m_less, m_exact, m_more, m_acc, m_rej;
  int m_chg;

  coin_acceptor dut (
    .clock(clock), .reset_L(reset_L), .coin_valid(coin_valid), .coin_in(coin_in),
    .go(go), .cost(cost), .result_ack(result_ack), .dispense_valid(dispense_valid),
    .dispense_coin(dispense_coin), .coin_accept(coin_accept), .coin_reject(coin_reject),
    .Paid(Paid), .result_valid(result_valid), .less(less), .exact(exact), .more(more),
    .change(change), .Pentagons(Pentagons), .Triangles(Triangles), .Circles(Circles)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int coin_value(input logic [2:0] c);
    case (c)
      3'b001:  return 1;
      3'b011:  return 3;
      3'b101:  return 5;
      default: return 0;
    endcase
  endfunction

  // Type index: 0 circle, 1 triangle, 2 pentagon, -1 invalid
  function automatic int coin_index(input logic [2:0] c);
    case (c)
      3'b001:  return 0;
      3'b011:  return 1;
      3'b101:  return 2;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_paid = 0;
    for (int k = 0; k < 3; k++) m_cnt[k] = 0;
    m_eval = 0; m_less = 0; m_exact = 0; m_more = 0; m_chg = 0;
    m_acc = 0; m_rej = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_step();
    int v, ci, di;
    bit acc, rej, inc, dec;
    acc = 0; rej = 0;
    v  = coin_value(coin_in);
    ci = coin_index(coin_in);
    di = dispense_valid ? coin_index(dispense_coin) : -1;
    if (coin_valid) begin
      if (!m_eval && v != 0 && m_cnt[ci] < 3 && m_paid + v <= 15) acc = 1;
      else rej = 1;
    end
    for (int k = 0; k < 3; k++) begin
      inc = acc && (ci == k);
      dec = (di == k);
      if (inc && !dec) m_cnt[k]++;
      else if (dec && !inc && m_cnt[k] > 0) m_cnt[k]--;
    end
    if (m_eval) begin
      if (result_ack) begin
        if (!m_less) m_paid = 0;
        m_eval = 0; m_less = 0; m_exact = 0; m_more = 0; m_chg = 0;
      end
    end else begin
      if (acc) m_paid = m_paid + v;
      if (go) begin
        m_eval  = 1;
        m_less  = (m_paid <  int'(cost));
        m_exact = (m_paid == int'(cost));
        m_more  = (m_paid >  int'(cost));
        m_chg   = m_more ? m_paid - int'(cost) : 0;
      end
    end
    m_acc = acc;
    m_rej = rej;
  endtask

  task automatic check_all();
    chk("accept", {31'd0, coin_accept}, {31'd0, m_acc});
    chk("reject", {31'd0, coin_reject}, {31'd0, m_rej});
    chk("paid",   {28'd0, Paid}, m_paid);
    chk("result", {24'd0, result_valid, less, exact, more, change},
                  {24'd0, m_eval, m_less, m_exact, m_more, 4'(m_chg)});
    chk("inventory", {26'd0, Pentagons, Triangles, Circles},
                     {26'd0, 2'(m_cnt[2]), 2'(m_cnt[1]), 2'(m_cnt[0])});
  endtask

  // One clock: apply inputs just after a falling edge, check at the next falling edge
  task automatic cyc(input logic cv, input logic [2:0] ci, input logic g, input logic [3:0] c,
                     input logic ack, input logic dv, input logic [2:0] dc);
    coin_valid = cv; coin_in = ci; go = g; cost = c;
    result_ack = ack; dispense_valid = dv; dispense_coin = dc;
    model_step();
    @(negedge clock);
    check_all();
  endtask

  task automatic coin(input logic [2:0] ci);
    cyc(1, ci, 0, 0, 0, 0, 0);
  endtask

  task automatic buy(input logic [3:0] c);
    cyc(0, 0, 1, c, 0, 0, 0);
  endtask

  task automatic ack();
    cyc(0, 0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    reset_L = 1'b0;
    coin_valid = 0; coin_in = 0; go = 0; cost = 0;
    result_ack = 0; dispense_valid = 0; dispense_coin = 0;
    model_reset();
    repeat (2) @(negedge clock);
    check_all();
    reset_L = 1'b1;

    // 5+3+1 against cost 7
    coin(3'b101); coin(3'b011); coin(3'b001);
    buy(4'd7);
    chk("s1_paid", {28'd0, Paid}, 9);
    chk("s1_flags", {28'd0, less, exact, more, result_valid}, 4'b0011);
    chk("s1_change", {28'd0, change}, 2);
    ack();
    chk("s1_after", {24'd0, Paid, Pentagons, Triangles, Circles}, {24'd0, 4'd0, 6'b01_01_01});

    // Short payment then top-up
    coin(3'b011); buy(4'd5);
    chk("s2_less", {29'd0, less, exact, more}, 3'b100);
    chk("s2_change", {28'd0, change}, 0);
    ack();
    chk("s2_keep", {28'd0, Paid}, 3);
    coin(3'b011); buy(4'd5);
    chk("s2_more", {28'd0, more, change}, {28'd0, 1'b1, 4'd1});
    ack();

    // Pentagon capacity and total overflow
    cyc(0, 0, 0, 0, 0, 1, 3'b101);
    coin(3'b101); coin(3'b101); coin(3'b101); coin(3'b101);
    chk("s3_reject", {31'd0, coin_reject}, 1);
    chk("s3_state", {26'd0, Paid, Pentagons}, {26'd0, 4'd15, 2'd3});
    coin(3'b001);
    chk("s3_ovf", {28'd0, coin_reject, Paid[2:0]}, {28'd0, 1'b1, 3'd7});
    buy(4'd15);
    chk("s3_exact", {31'd0, exact}, 1);
    ack();

    // Insert and dispense a circle together, then drain to zero
    cyc(1, 3'b001, 0, 0, 0, 1, 3'b001);
    chk("s4_same", {30'd0, Circles}, 1);
    cyc(0, 0, 0, 0, 0, 1, 3'b001);
    cyc(0, 0, 0, 0, 0, 1, 3'b001);
    chk("s4_floor", {30'd0, Circles}, 0);

    // Coin and go during EVAL are refused or ignored
    buy(4'd3);
    coin(3'b011);
    chk("s5_rej", {28'd0, coin_reject, less, more, result_valid}, 4'b1101);
    buy(4'd0);
    chk("s5_hold", {29'd0, less, exact, more}, 3'b100);

    // Asynchronous reset while a result is pending
    reset_L = 1'b0;
    #1;
    chk("s6_rst", {10'd0, coin_accept, coin_reject, Paid, result_valid, less, exact, more,
                   change, Pentagons, Triangles, Circles}, 32'd0);
    model_reset();
    @(negedge clock);
    reset_L = 1'b1;
    coin(3'b010);
    chk("s6_inval", {31'd0, coin_reject}, 1);
    buy(4'd0);
    chk("s6_zero", {29'd0, exact, less, more}, 3'b100);
    ack();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] codes[8];
      codes = '{3'b001, 3'b011, 3'b101, 3'b001, 3'b011, 3'b101, 3'b010, 3'b111};
      cyc($urandom_range(0, 2) == 0, codes[$urandom_range(0, 7)],
          $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)),
          $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
          codes[$urandom_range(0, 7)]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports SHALL be, one per line:
- clock  input  1  rising-edge system clock
- reset_L  input  1  asynchronous active-low reset
- coin_valid  input  1  one-cycle strobe, coin presented
- coin_in  input  3  coin code: 3'b001 circle (1), 3'b011 triangle (3), 3'b101 pentagon (5); any other code is invalid
- go  input  1  purchase request strobe
- cost  input  4  item cost, sampled on accepted go
- result_ack  input  1  consumer has taken the result
- dispense_valid  input  1  one-cycle strobe, one coin leaves the inventory
- dispense_coin  input  3  code of the dispensed coin
- coin_accept  output  1  registered one-cycle pulse, coin taken
- coin_reject  output  1  registered one-cycle pulse, coin refused
- Paid  output  4  running total of the current transaction
- result_valid  output  1  high while less/exact/more/change are valid
- less, exact, more  output  1 each  Paid < cost, Paid == cost, Paid > cost
- change  output  4  Paid - cost when more, else 0
- Pentagons, Triangles, Circles  output  2 each  coins held, 0..3

Function
REQ-002 FSM states SHALL be IDLE, COLLECT, EVAL; reset state IDLE.
REQ-003 A coin SHALL be accepted only if: coin_valid=1; state is IDLE or COLLECT; code is valid; the matching inventory count is < 3; Paid + value <= 15.
REQ-004 On an accepted coin, next edge: Paid += value, matching count +1, coin_accept=1 for one cycle; IDLE -> COLLECT.
REQ-005 A coin with coin_valid=1 that fails REQ-003 SHALL give coin_reject=1 for one cycle next edge, with Paid and inventory unchanged.
REQ-006 go in IDLE or COLLECT SHALL latch cost and move to EVAL next edge; go in EVAL SHALL be ignored.
REQ-007 A coin and go in the same cycle: the coin SHALL be judged per REQ-003 and, if accepted, included in Paid before evaluation.
REQ-008 In EVAL: result_valid=1; exactly one of less/exact/more =1, computed from registered Paid and latched cost; change = Paid - latched cost when more, else 0. Outputs SHALL be registered and held stable until acknowledged.
REQ-009 result_ack in EVAL: if less -> COLLECT with Paid retained; else -> IDLE with Paid=0. result_ack outside EVAL SHALL be ignored.
REQ-010 result_valid SHALL be 1 from the first EVAL cycle; minimum go-to-result_valid latency is 1 cycle; result_ack in that same first cycle SHALL be honoured.
REQ-011 go in IDLE with Paid=0 SHALL evaluate normally: cost=0 gives exact, otherwise less.
REQ-012 Outside EVAL, result_valid, less, exact, more and change SHALL be 0.
REQ-013 dispense_valid with a valid code SHALL decrement the matching count next edge, in any state; at 0 it SHALL stay 0. An invalid dispense code SHALL be ignored.
REQ-014 Accepted coin and dispense of the same type in one cycle SHALL leave that count unchanged; different types SHALL update independently.
REQ-015 Inventory SHALL persist across transactions; only reset clears it.
REQ-016 All arithmetic SHALL be 4-bit unsigned; the REQ-003 overflow guard SHALL be evaluated at 5 bits.

Reset
REQ-017 reset_L=0 SHALL immediately force IDLE, Paid=0, inventory=0 and all outputs 0, including in mid-transaction or in EVAL.
REQ-018 Events present in the first edge after reset deasserts SHALL be processed normally.

Verification
REQ-019 The bench SHALL cover:
- Coins 5,3,1 then go with cost=7 -> Paid=9, more=1, change=2; ack -> IDLE, Paid=0, Pentagons=1, Triangles=1, Circles=1.
- Coin 3, go with cost=5 -> less=1, change=0; ack -> COLLECT, Paid=3; coin 3, go -> more=1, change=1.
- Four pentagons -> the 4th gives coin_reject (count=3, Paid=15); a circle with Paid=15 -> reject.
- Circles=1: circle insert and circle dispense in the same cycle -> Circles stays 1; dispense with Circles=0 -> stays 0.
- Coin during EVAL -> reject, results unchanged; go in EVAL -> ignored.
- reset_L low during EVAL -> all outputs 0 asynchronously; invalid code 3'b010 -> reject.
